// File: rtl/x_scope_readout.sv
// Autonomous readout of the x_micro_scope capture RAM: streams a window of words, LSB byte first, to x_uart_tx.
// Optional trailing checksum byte when X_SCOPE_READOUT_CHECKSUM_EN is defined.
module x_scope_readout #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_scope_busy,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  output logic [7:0]        o_data,
  input  logic              i_accept
);

  localparam int NB    = DATA_W / 8;
  localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4,
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
    ST_CSUM  = 3'd5,
`endif
    ST_DONE  = 3'd6
  } state_e;

`ifdef X_SCOPE_READOUT_CHECKSUM_EN
  localparam state_e ST_AFTER_LAST = ST_CSUM;
`else
  localparam state_e ST_AFTER_LAST = ST_DONE;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    rem_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [BI_W-1:0]     bidx_q;
  logic                abort_q;
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic last_byte, last_word;
  assign last_byte = (bidx_q == BI_W'(NB - 1));
  assign last_word = (rem_q == CNT_W'(1));
  assign o_raddr   = addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      bidx_q  <= '0;
      abort_q <= 1'b0;
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (i_start) begin
          addr_q  <= i_base;
          rem_q   <= i_count;
          abort_q <= 1'b0;
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
          sum_q   <= '0;
`endif
        end
        ST_LATCH: begin
          shreg_q <= i_rdata;
          bidx_q  <= '0;
        end
        ST_SEND: begin
          // An abort seen while a byte is pending is remembered until that byte is taken.
          if (i_abort) abort_q <= 1'b1;
          if (i_accept) begin
            shreg_q <= {8'h00, shreg_q[DATA_W-1:8]};
            bidx_q  <= bidx_q + BI_W'(1);
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
            sum_q   <= sum_q + shreg_q[7:0];
`endif
            if (last_byte) begin
              addr_q <= addr_q + ADDR_W'(1);
              rem_q  <= rem_q - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    o_busy  = (state_q != ST_IDLE);
    o_done  = 1'b0;
    o_ren   = 1'b0;
    o_valid = 1'b0;
    o_data  = '0;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_abort || rem_q == '0) state_d = ST_DONE;
        else if (!i_scope_busy)     state_d = ST_READ;
      end
      ST_READ: begin
        o_ren   = 1'b1;
        state_d = i_abort ? ST_DONE : ST_LATCH;
      end
      ST_LATCH: state_d = i_abort ? ST_DONE : ST_SEND;
      ST_SEND: begin
        o_valid = 1'b1;
        o_data  = shreg_q[7:0];
        if (i_accept) begin
          if (abort_q || i_abort) state_d = ST_DONE;
          else if (last_byte)     state_d = last_word ? ST_AFTER_LAST : ST_WAIT;
        end
      end
`ifdef X_SCOPE_READOUT_CHECKSUM_EN
      ST_CSUM: begin
        o_valid = 1'b1;
        o_data  = sum_q;
        if (i_accept) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_x_scope_readout.sv
// Directed self-checking bench for x_scope_readout with a registered-read scope RAM model.
module tb_x_scope_readout;

`ifdef X_SCOPE_READOUT_CHECKSUM_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  logic        i_clk, i_rst, i_start, i_abort, i_scope_busy, i_accept;
  logic [10:0] i_base;
  logic [11:0] i_count;
  logic [31:0] i_rdata;
  logic        o_busy, o_done, o_ren, o_valid;
  logic [10:0] o_raddr;
  logic [7:0]  o_data;

  logic [31:0] mem [0:2047];

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0]  byte_q [0:31];
  logic [10:0] ren_addr [0:15];
  int nbytes, nren, first_valid, stable_errs;
  logic done_seen;

  x_scope_readout dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_base(i_base), .i_count(i_count), .o_busy(o_busy), .o_done(o_done),
    .i_scope_busy(i_scope_busy), .o_ren(o_ren), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_valid(o_valid), .o_data(o_data), .i_accept(i_accept)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_ren) i_rdata <= mem[o_raddr];

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] base, input logic [11:0] count, input logic abort);
    i_base  = base;
    i_count = count;
    i_start = 1'b1;
    i_abort = abort;
    tick;
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  // Drives i_accept (held off 'stall' cycles per byte, or held high when stall is 0),
  // records bytes and read addresses, and stops at the o_done pulse.
  task automatic run_dump(input int stall, input int abort_at, input int max_cyc);
    int hold;
    logic [7:0] held;
    hold = 0; held = 8'h00;
    nbytes = 0; nren = 0; first_valid = -1; stable_errs = 0; done_seen = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (o_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (o_ren === 1'b1) begin
        if (nren < 16) ren_addr[nren] = o_raddr;
        nren++;
      end
      i_abort = 1'b0;
      if (o_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (hold == 0) held = o_data;
        else if (o_data !== held) stable_errs++;
        if (nbytes == abort_at && hold == 0) i_abort = 1'b1;
        if (hold >= stall) begin
          i_accept = 1'b1;
          if (nbytes < 32) byte_q[nbytes] = o_data;
          nbytes++;
          hold = 0;
        end else begin
          i_accept = 1'b0;
          hold++;
        end
      end else begin
        if (hold != 0) stable_errs++;
        i_accept = (stall == 0);
      end
      tick;
    end
    i_abort  = 1'b0;
    i_accept = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick; tick;
    n_checks++;
    if ({o_busy, o_done, o_ren, o_valid, o_raddr, o_data} !== 23'd0) begin
      n_errs++;
      $display("FAIL reset_outputs: got busy=%b done=%b ren=%b valid=%b raddr=%h data=%h, want all zero",
               o_busy, o_done, o_ren, o_valid, o_raddr, o_data);
    end
    i_rst = 1'b0;
    tick;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errs++;
      $display("FAIL reset_idle: busy=%b, want 0", o_busy);
    end
  endtask

  task automatic test_single_word;
    logic [7:0] exp [0:4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    mem[5] = 32'h44332211;
    // Simultaneous abort with start in IDLE must be ignored.
    do_start(11'd5, 12'd1, 1'b1);
    run_dump(0, -1, 60);
    n_checks++;
    if (done_seen !== 1'b1) begin n_errs++; $display("FAIL single_done: no o_done within budget"); end
    n_checks++;
    if (nbytes !== 4 + CS_EN) begin n_errs++; $display("FAIL single_count: got %0d bytes, want %0d", nbytes, 4 + CS_EN); end
    for (int i = 0; i < 4 + CS_EN && i < nbytes; i++) begin
      n_checks++;
      if (byte_q[i] !== exp[i]) begin n_errs++; $display("FAIL single_byte%0d: got %h, want %h", i, byte_q[i], exp[i]); end
    end
    n_checks++;
    if (first_valid !== 4) begin n_errs++; $display("FAIL single_latency: first valid cycle %0d, want 4", first_valid); end
    n_checks++;
    if (nren !== 1 || ren_addr[0] !== 11'h005) begin
      n_errs++; $display("FAIL single_ren: got %0d reads first addr %h, want 1 read at 005", nren, ren_addr[0]);
    end
    tick;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_errs++; $display("FAIL single_idle: busy=%b done=%b, want 0 0", o_busy, o_done); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [0:8];
    exp = '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h87};
    mem[11'h7FF] = 32'hA0A1A2A3;
    mem[11'h000] = 32'h00000001;
    do_start(11'h7FF, 12'd2, 1'b0);
    run_dump(0, -1, 80);
    n_checks++;
    if (done_seen !== 1'b1) begin n_errs++; $display("FAIL wrap_done: no o_done within budget"); end
    n_checks++;
    if (nren !== 2 || ren_addr[0] !== 11'h7FF || ren_addr[1] !== 11'h000) begin
      n_errs++; $display("FAIL wrap_raddr: got %0d reads %h %h, want 2 reads 7ff 000", nren, ren_addr[0], ren_addr[1]);
    end
    n_checks++;
    if (nbytes !== 8 + CS_EN) begin n_errs++; $display("FAIL wrap_count: got %0d bytes, want %0d", nbytes, 8 + CS_EN); end
    for (int i = 0; i < 8 + CS_EN && i < nbytes; i++) begin
      n_checks++;
      if (byte_q[i] !== exp[i]) begin n_errs++; $display("FAIL wrap_byte%0d: got %h, want %h", i, byte_q[i], exp[i]); end
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [0:4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    do_start(11'd5, 12'd1, 1'b0);
    run_dump(5, -1, 120);
    n_checks++;
    if (done_seen !== 1'b1) begin n_errs++; $display("FAIL stall_done: no o_done within budget"); end
    n_checks++;
    if (stable_errs !== 0) begin n_errs++; $display("FAIL stall_stable: %0d hold violations, want 0", stable_errs); end
    n_checks++;
    if (nbytes !== 4 + CS_EN) begin n_errs++; $display("FAIL stall_count: got %0d bytes, want %0d", nbytes, 4 + CS_EN); end
    for (int i = 0; i < 4 + CS_EN && i < nbytes; i++) begin
      n_checks++;
      if (byte_q[i] !== exp[i]) begin n_errs++; $display("FAIL stall_byte%0d: got %h, want %h", i, byte_q[i], exp[i]); end
    end
    tick;
  endtask

  task automatic test_scope_busy;
    int early_reads;
    early_reads = 0;
    i_scope_busy = 1'b1;
    do_start(11'd5, 12'd1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (o_ren === 1'b1) early_reads++;
      tick;
    end
    n_checks++;
    if (early_reads !== 0 || o_busy !== 1'b1) begin
      n_errs++; $display("FAIL busy_hold: %0d reads while scope busy, busy=%b, want 0 reads busy=1", early_reads, o_busy);
    end
    i_scope_busy = 1'b0;
    run_dump(0, -1, 60);
    n_checks++;
    if (done_seen !== 1'b1 || nren !== 1 || nbytes !== 4 + CS_EN) begin
      n_errs++; $display("FAIL busy_resume: done=%b reads=%0d bytes=%0d, want 1 1 %0d", done_seen, nren, nbytes, 4 + CS_EN);
    end
    n_checks++;
    if (byte_q[0] !== 8'h11 || byte_q[3] !== 8'h44) begin
      n_errs++; $display("FAIL busy_bytes: got %h..%h, want 11..44", byte_q[0], byte_q[3]);
    end
    tick;
  endtask

  task automatic test_abort;
    mem[11'h010] = 32'h0D0C0B0A;
    mem[11'h011] = 32'h1D1C1B1A;
    mem[11'h012] = 32'h2D2C2B2A;
    do_start(11'h010, 12'd3, 1'b0);
    run_dump(2, 1, 80);
    n_checks++;
    if (done_seen !== 1'b1) begin n_errs++; $display("FAIL abort_done: no o_done within budget"); end
    n_checks++;
    if (nbytes !== 2) begin n_errs++; $display("FAIL abort_count: got %0d bytes, want 2", nbytes); end
    n_checks++;
    if (byte_q[0] !== 8'h0A || byte_q[1] !== 8'h0B) begin
      n_errs++; $display("FAIL abort_bytes: got %h %h, want 0a 0b", byte_q[0], byte_q[1]);
    end
    n_checks++;
    if (nren !== 1) begin n_errs++; $display("FAIL abort_reads: got %0d reads, want 1", nren); end
    tick;
  endtask

  task automatic test_count_zero;
    do_start(11'd5, 12'd0, 1'b0);
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_ren !== 1'b0 || o_valid !== 1'b0) begin
      n_errs++; $display("FAIL zero_c1: busy=%b done=%b ren=%b valid=%b, want 1 0 0 0", o_busy, o_done, o_ren, o_valid);
    end
    tick;
    n_checks++;
    if (o_done !== 1'b1 || o_ren !== 1'b0 || o_valid !== 1'b0) begin
      n_errs++; $display("FAIL zero_c2: done=%b ren=%b valid=%b, want 1 0 0", o_done, o_ren, o_valid);
    end
    tick;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_errs++; $display("FAIL zero_c3: busy=%b done=%b, want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_reset_mid_send;
    i_accept = 1'b0;
    do_start(11'd5, 12'd1, 1'b0);
    // A second start while busy must not reload the window.
    i_start = 1'b1;
    i_base  = 11'h010;
    tick;
    i_start = 1'b0;
    tick; tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h11) begin
      n_errs++; $display("FAIL rst_send: valid=%b data=%h, want 1 11", o_valid, o_data);
    end
    i_rst = 1'b1;
    tick;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid: valid=%b busy=%b done=%b, want 0 0 0", o_valid, o_busy, o_done);
    end
    i_rst = 1'b0;
    tick;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_errs++; $display("FAIL rst_after: done=%b busy=%b, want 0 0", o_done, o_busy);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_scope_busy = 1'b0; i_accept = 1'b0;
    i_base = '0; i_count = '0; i_rdata = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    test_reset;
    test_single_word;
    test_wrap;
    test_backpressure;
    test_scope_busy;
    test_abort;
    test_count_zero;
    test_reset_mid_send;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
